debugger_rx: RTL and testbench
==============================

Name: debugger_rx

Overview:
- Host-to-target half of the debug link.
- Consumes bytes from the UART receiver and decodes host commands: load program, run, single step, dump state.
- Streams program words into instruction memory and pulses control strobes to the CPU, and to the debug transmitter's send request.

Parameters:
- ADDR_WIDTH, 10, instruction-memory word-address width; max program = 2^ADDR_WIDTH words.
- TIMEOUT_CYCLES, 50000000, max clk cycles allowed between bytes inside a command before abort.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_done_tick  in  1  one-cycle strobe: r_data holds a new received byte.
- r_data  in  8  received byte.
- mem_we  out  1  instruction-memory write strobe (one cycle).
- mem_addr  out  ADDR_WIDTH  word address for mem_wdata.
- mem_wdata  out  32  assembled instruction word.
- cmd_run  out  1  one-cycle pulse: free-run CPU.
- cmd_step  out  1  one-cycle pulse: execute one clock step.
- cmd_dump  out  1  one-cycle pulse: request state frame transmission (drives the transmitter's send signal).
- prog_done  out  1  one-cycle pulse: program load completed.
- busy  out  1  high while inside a multi-byte command.
- err  out  1  one-cycle pulse: protocol error.

Behaviour:
- All outputs registered. Reset (reset=0, async) forces state IDLE, all outputs 0, counters 0, timeout counter 0.
- Opcodes, valid only in IDLE: 0x01 LOAD, 0x02 RUN, 0x03 STEP, 0x04 DUMP.
- Any other byte in IDLE: err pulse, stay IDLE.
- RUN/STEP/DUMP: matching pulse asserted in the cycle after the rx_done_tick carrying the opcode; stay IDLE.
- LOAD frame: opcode, LEN_HI, LEN_LO (16-bit word count N, big-endian), then N*4 data bytes, each word MSB byte first.
- FSM states: IDLE, LEN_HI, LEN_LO, DATA.
  - IDLE -(0x01)-> LEN_HI -(byte)-> LEN_LO -(byte)-> DATA, or back to IDLE.
  - DATA -(last byte of word N-1)-> IDLE.
- busy = 1 in LEN_HI, LEN_LO, DATA.
- LEN_LO exit:
  - N == 0: prog_done pulses next cycle, no writes, go IDLE.
  - N > 2^ADDR_WIDTH: err pulses next cycle, go IDLE. Following bytes are decoded as opcodes.
  - Otherwise: word address counter = 0, byte counter = 0, go DATA.
- DATA:
  - Each byte shifts into a 32-bit assembly register (shift left 8, new byte in bits 7:0); 2-bit byte counter increments.
  - On the 4th byte, in the next cycle: mem_we=1, mem_wdata = assembled word, mem_addr = current word index. Word index then increments; byte counter wraps to 0.
  - Word k is written at address k. Addresses never wrap, because N is bounded.
  - prog_done pulses in the same cycle as the final mem_we; state returns to IDLE.
- mem_addr and mem_wdata hold their last values when mem_we=0.
- Timeout:
  - Counter clears on every rx_done_tick and increments each cycle while busy.
  - On reaching TIMEOUT_CYCLES: err pulse, go IDLE, discard the partial word. Words already written stay written.
  - Counter is held at 0 in IDLE.
- rx_done_tick during the mem_we cycle is accepted normally. Throughput is one byte per cycle, so no bytes are lost.
- Reset mid-load: immediate abort, no further writes, and no prog_done or err pulse.
- err and prog_done are never asserted together; at most one command pulse is asserted per cycle.

Test Plan:
- Bytes 0x02, then 0x03, then 0x04, spaced 20 cycles -> single cmd_run, cmd_step, cmd_dump pulses, each 1 cycle after its tick; busy stays 0.
- LOAD N=2: 01 00 02 | 12 34 56 78 | 9A BC DE F0 -> mem_we at addr 0 with data 0x12345678, then at addr 1 with 0x9ABCDEF0; prog_done coincident with the second write; busy drops afterwards.
- LOAD N=0 (01 00 00) -> prog_done 1 cycle after the third byte, no mem_we. Byte 0x7F in IDLE -> err pulse, state remains IDLE.
- ADDR_WIDTH=4: LOAD with N=17 (01 00 11) -> err pulse, IDLE. A following 0x02 -> cmd_run.
- TIMEOUT_CYCLES=100: LOAD N=1 with only 2 data bytes, then silence -> err exactly 100 cycles after the last tick, no mem_we. A new LOAD N=1 (AA BB CC DD) -> 0xAABBCCDD written at addr 0.
- Drive reset low mid-DATA of an N=3 load, release, send 0x04 -> all outputs 0 during reset, no further writes, cmd_dump pulses normally after release.

Source files
------------

// File: rtl/debugger_rx.sv
// Host-to-target command decoder for the debug link: turns received UART bytes
// into instruction-memory writes and one-cycle CPU / transmitter control strobes.
module debugger_rx #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 50000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rx_done_tick,
  input  logic [7:0]            r_data,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  cmd_run,
  output logic                  cmd_step,
  output logic                  cmd_dump,
  output logic                  prog_done,
  output logic                  busy,
  output logic                  err
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LEN_HI = 2'd1,
    S_LEN_LO = 2'd2,
    S_DATA   = 2'd3
  } state_t;

  // Counter value in the last silent cycle before the abort pulse, so err lands
  // exactly TIMEOUT_CYCLES cycles after the last received byte.
  localparam logic [31:0] TMO_LAST  = 32'(TIMEOUT_CYCLES - 2);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [7:0]            r_len_hi,   w_len_hi_nxt;
  logic [ADDR_WIDTH-1:0] r_last_idx, w_last_idx_nxt;
  logic [ADDR_WIDTH-1:0] r_word_idx, w_word_idx_nxt;
  logic [1:0]            r_byte_cnt, w_byte_cnt_nxt;
  logic [31:0]           r_shift,    w_shift_nxt;
  logic [31:0]           r_tmo,      w_tmo_nxt;
  logic                  r_mem_we,   w_mem_we_nxt;
  logic [ADDR_WIDTH-1:0] r_mem_addr, w_mem_addr_nxt;
  logic [31:0]           r_mem_wdata, w_mem_wdata_nxt;
  logic                  r_cmd_run,  w_cmd_run_nxt;
  logic                  r_cmd_step, w_cmd_step_nxt;
  logic                  r_cmd_dump, w_cmd_dump_nxt;
  logic                  r_prog_done, w_prog_done_nxt;
  logic                  r_busy,     w_busy_nxt;
  logic                  r_err,      w_err_nxt;

  logic [15:0] w_len;
  logic [15:0] w_len_m1;
  logic        w_len_zero;
  logic        w_len_big;
  logic [31:0] w_word;
  logic        w_in_cmd;
  logic        w_tmo_hit;
  logic        w_last_word;

  assign w_len       = {r_len_hi, r_data};
  assign w_len_m1    = w_len - 16'd1;
  assign w_len_zero  = (w_len == 16'd0);
  assign w_len_big   = ({1'b0, w_len} > MAX_WORDS);
  assign w_word      = {r_shift[23:0], r_data};
  assign w_in_cmd    = (r_state != S_IDLE);
  assign w_tmo_hit   = w_in_cmd && !rx_done_tick && (r_tmo == TMO_LAST);
  assign w_last_word = (r_byte_cnt == 2'd3) && (r_word_idx == r_last_idx);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (rx_done_tick && (r_data == 8'h01)) begin
          w_state_nxt = S_LEN_HI;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_LEN_HI: begin
        if (rx_done_tick) begin
          w_state_nxt = S_LEN_LO;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LEN_HI;
        end
      end
      S_LEN_LO: begin
        if (rx_done_tick) begin
          if (w_len_zero || w_len_big) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_DATA;
          end
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_LEN_LO;
        end
      end
      S_DATA: begin
        if (rx_done_tick && w_last_word) begin
          w_state_nxt = S_IDLE;
        end else if (w_tmo_hit) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DATA;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output and datapath next values (all registered below)
  always_comb begin
    w_mem_we_nxt    = 1'b0;
    w_cmd_run_nxt   = 1'b0;
    w_cmd_step_nxt  = 1'b0;
    w_cmd_dump_nxt  = 1'b0;
    w_prog_done_nxt = 1'b0;
    w_err_nxt       = 1'b0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_len_hi_nxt    = r_len_hi;
    w_last_idx_nxt  = r_last_idx;
    w_word_idx_nxt  = r_word_idx;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_shift_nxt     = r_shift;
    w_busy_nxt      = (w_state_nxt != S_IDLE);
    if (!w_busy_nxt || rx_done_tick) begin
      w_tmo_nxt = 32'd0;
    end else begin
      w_tmo_nxt = r_tmo + 32'd1;
    end
    case (r_state)
      S_IDLE: begin
        if (rx_done_tick) begin
          case (r_data)
            8'h01:   w_busy_nxt     = 1'b1;
            8'h02:   w_cmd_run_nxt  = 1'b1;
            8'h03:   w_cmd_step_nxt = 1'b1;
            8'h04:   w_cmd_dump_nxt = 1'b1;
            default: w_err_nxt      = 1'b1;
          endcase
        end else begin
          w_err_nxt = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (rx_done_tick) begin
          w_len_hi_nxt = r_data;
        end else begin
          w_err_nxt = w_tmo_hit;
        end
      end
      S_LEN_LO: begin
        if (rx_done_tick) begin
          if (w_len_zero) begin
            w_prog_done_nxt = 1'b1;
          end else if (w_len_big) begin
            w_err_nxt = 1'b1;
          end else begin
            w_word_idx_nxt = '0;
            w_byte_cnt_nxt = 2'd0;
            w_last_idx_nxt = w_len_m1[ADDR_WIDTH-1:0];
          end
        end else begin
          w_err_nxt = w_tmo_hit;
        end
      end
      S_DATA: begin
        if (rx_done_tick) begin
          w_shift_nxt    = w_word;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_mem_we_nxt    = 1'b1;
            w_mem_wdata_nxt = w_word;
            w_mem_addr_nxt  = r_word_idx;
            w_word_idx_nxt  = r_word_idx + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            w_prog_done_nxt = w_last_word;
          end else begin
            w_mem_we_nxt = 1'b0;
          end
        end else begin
          w_err_nxt = w_tmo_hit;
        end
      end
      default: w_err_nxt = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_len_hi    <= 8'd0;
      r_last_idx  <= '0;
      r_word_idx  <= '0;
      r_byte_cnt  <= 2'd0;
      r_shift     <= 32'd0;
      r_tmo       <= 32'd0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_cmd_run   <= 1'b0;
      r_cmd_step  <= 1'b0;
      r_cmd_dump  <= 1'b0;
      r_prog_done <= 1'b0;
      r_busy      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_len_hi    <= w_len_hi_nxt;
      r_last_idx  <= w_last_idx_nxt;
      r_word_idx  <= w_word_idx_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_tmo       <= w_tmo_nxt;
      r_mem_we    <= w_mem_we_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_cmd_run   <= w_cmd_run_nxt;
      r_cmd_step  <= w_cmd_step_nxt;
      r_cmd_dump  <= w_cmd_dump_nxt;
      r_prog_done <= w_prog_done_nxt;
      r_busy      <= w_busy_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cmd_run   = r_cmd_run;
  assign cmd_step  = r_cmd_step;
  assign cmd_dump  = r_cmd_dump;
  assign prog_done = r_prog_done;
  assign busy      = r_busy;
  assign err       = r_err;

endmodule

// File: tb/tb_debugger_rx.sv
// Bench for debugger_rx: directed and randomized byte streams compared every
// cycle against a byte-list protocol model of the host command set.
module tb_debugger_rx;
  localparam int AW  = 4;
  localparam int TMO = 100;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          rx_done_tick = 1'b0;
  logic [7:0]    r_data = 8'd0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          cmd_run, cmd_step, cmd_dump, prog_done, busy, err;

  always #5 clk = ~clk;

  debugger_rx #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .r_data(r_data),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_dump(cmd_dump),
    .prog_done(prog_done), .busy(busy), .err(err)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: the bytes of the current LOAD command are kept in a list;
  // expected outputs for the next cycle follow from the list length and content.
  bit         m_in_cmd = 1'b0;
  logic [7:0] m_q[$];
  int         m_silent = 0;
  int         m_n = 0;
  logic          e_run = 1'b0, e_step = 1'b0, e_dump = 1'b0, e_pd = 1'b0;
  logic          e_err = 1'b0, e_we = 1'b0, e_busy = 1'b0;
  logic [AW-1:0] e_addr = '0;
  logic [31:0]   e_wdata = 32'd0;

  task automatic model_reset();
    m_in_cmd = 1'b0; m_q.delete(); m_silent = 0;
    e_run = 1'b0; e_step = 1'b0; e_dump = 1'b0; e_pd = 1'b0;
    e_err = 1'b0; e_we = 1'b0; e_busy = 1'b0; e_addr = '0; e_wdata = 32'd0;
  endtask

  task automatic model_step(input logic tk, input logic [7:0] d);
    int s;
    int w;
    e_run = 1'b0; e_step = 1'b0; e_dump = 1'b0; e_pd = 1'b0; e_err = 1'b0; e_we = 1'b0;
    if (!m_in_cmd) begin
      if (tk) begin
        if (d == 8'h01) begin
          m_in_cmd = 1'b1; m_q.delete(); m_silent = 0;
        end else if (d == 8'h02) e_run = 1'b1;
        else if (d == 8'h03) e_step = 1'b1;
        else if (d == 8'h04) e_dump = 1'b1;
        else e_err = 1'b1;
      end
    end else if (tk) begin
      m_silent = 0;
      m_q.push_back(d);
      s = m_q.size();
      if (s == 2) begin
        m_n = int'({m_q[0], m_q[1]});
        if (m_n == 0) begin
          e_pd = 1'b1; m_in_cmd = 1'b0;
        end else if (m_n > (1 << AW)) begin
          e_err = 1'b1; m_in_cmd = 1'b0;
        end
      end else if (s > 2 && ((s - 2) % 4 == 0)) begin
        w = (s - 2) / 4 - 1;
        e_we = 1'b1;
        e_addr = AW'(w);
        e_wdata = {m_q[s-4], m_q[s-3], m_q[s-2], m_q[s-1]};
        if (w == m_n - 1) begin
          e_pd = 1'b1; m_in_cmd = 1'b0;
        end
      end
    end else begin
      m_silent++;
      if (m_silent == TMO - 1) begin
        e_err = 1'b1; m_in_cmd = 1'b0;
      end
    end
    e_busy = m_in_cmd;
  endtask

  // Per-cycle monitor: compare outputs, then advance the model with this cycle's inputs
  always begin
    @(negedge clk);
    if (!reset) model_reset();
    chk("cmd_run",   32'(cmd_run),   32'(e_run));
    chk("cmd_step",  32'(cmd_step),  32'(e_step));
    chk("cmd_dump",  32'(cmd_dump),  32'(e_dump));
    chk("prog_done", 32'(prog_done), 32'(e_pd));
    chk("err",       32'(err),       32'(e_err));
    chk("mem_we",    32'(mem_we),    32'(e_we));
    chk("busy",      32'(busy),      32'(e_busy));
    chk("mem_addr",  32'(mem_addr),  32'(e_addr));
    chk("mem_wdata", mem_wdata,      e_wdata);
    if (reset) model_step(rx_done_tick, r_data);
  end

  // Caller is positioned just after a rising edge; gap = idle cycles after the byte.
  task automatic send(input logic [7:0] b, input int gap);
    rx_done_tick = 1'b1;
    r_data = b;
    @(posedge clk); #1;
    rx_done_tick = 1'b0;
    r_data = 8'($urandom);
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_load(input int n, input int nbytes, input int maxgap);
    send(8'h01, $urandom_range(0, maxgap));
    send(8'(n >> 8), $urandom_range(0, maxgap));
    send(8'(n), $urandom_range(0, maxgap));
    for (int i = 0; i < nbytes; i++) send(8'($urandom), $urandom_range(0, maxgap));
  endtask

  initial begin
    idle(3);
    reset = 1'b1;
    idle(3);
    // single-byte commands
    send(8'h02, 20); send(8'h03, 20); send(8'h04, 20);
    // two-word load, back to back
    send(8'h01, 0); send(8'h00, 0); send(8'h02, 0);
    send(8'h12, 0); send(8'h34, 0); send(8'h56, 0); send(8'h78, 0);
    send(8'h9A, 0); send(8'hBC, 0); send(8'hDE, 0); send(8'hF0, 5);
    // empty load, bad opcode
    send(8'h01, 1); send(8'h00, 1); send(8'h00, 5);
    send(8'h7F, 5);
    // oversize load then a run
    send(8'h01, 0); send(8'h00, 0); send(8'h11, 0); send(8'h02, 5);
    send(8'h01, 0); send(8'h00, 0); send(8'h10, 0); send(8'h05, 5);
    // truncated load times out, then a good load
    send(8'h01, 0); send(8'h00, 0); send(8'h01, 0); send(8'hAA, 0); send(8'hBB, 130);
    send(8'h01, 0); send(8'h00, 0); send(8'h01, 0);
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 5);
    // longest legal silence inside a command
    send(8'h01, 0); send(8'h00, 0); send(8'h01, TMO - 2);
    send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 5);
    // reset in the middle of a three-word load
    send(8'h01, 0); send(8'h00, 0); send(8'h03, 0);
    for (int i = 0; i < 6; i++) send(8'(8'h40 + i), 0);
    reset = 1'b0;
    idle(3);
    reset = 1'b1;
    idle(2);
    send(8'h04, 5);
    // randomized command mix
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 4))
        0: send(8'($urandom_range(2, 4)), $urandom_range(0, 4));
        1: send(8'($urandom_range(5, 255)), $urandom_range(0, 4));
        2: begin
          int n = $urandom_range(0, 5);
          send_load(n, 4 * n, 3);
        end
        3: send_load($urandom_range(17, 300), 0, 2);
        default: begin
          send_load($urandom_range(1, 3), $urandom_range(0, 3), 2);
          idle(TMO + 5);
        end
      endcase
    end
    idle(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
